// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, TX FSM states
// and a constant-width helper used by both transmit and receive sides.
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int START_BITS = 1;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Power-of-two depth so the pointers wrap naturally.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DATA_BITS
) (
    input  logic                       CLK,
    input  logic                       RSTn,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [clog2(DEPTH):0]      count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign full    = (r_count == CW'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; push and pop together keep count.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_module.sv
// UART 8N1 transmitter with a byte FIFO in front of the serialiser.
// Line output and done pulse are registered one cycle behind the FSM.
module uart_tx_module
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int BAUD_DIV   = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 TX_En_Sig,
    input  logic [DATA_BITS-1:0] TX_Data,
    output logic                 TX_Full,
    output logic                 TX_Busy,
    output logic                 TX_Done_Sig,
    output logic                 TX_Ovf,
    output logic                 TX_Pin_Out
);

    localparam int BW = clog2(BAUD_DIV);
    localparam int IW = clog2(DATA_BITS);
    localparam int CW = clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);

    tx_state_t            r_state, w_state_nxt;
    logic [BW-1:0]        r_baud_cnt, w_baud_nxt;
    logic [IW-1:0]        r_bit_idx, w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_pin, w_pin_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_ovf;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_rd_data;
    logic [CW-1:0]        w_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .wr_en   (TX_En_Sig),
        .wr_data (TX_Data),
        .rd_en   (w_pop),
        .rd_data (w_rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_bit_end   = (r_baud_cnt == BAUD_LAST);
    assign TX_Full     = w_full;
    assign TX_Busy     = (r_state != IDLE) || (w_count != '0);
    assign TX_Done_Sig = r_done;
    assign TX_Ovf      = r_ovf;
    assign TX_Pin_Out  = r_pin;

    // FSM and datapath registers; reset drops any partial frame.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_pin      <= LINE_IDLE;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_pin      <= w_pin_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Sticky overflow: a write attempt while full is remembered.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_ovf <= 1'b0;
        else       r_ovf <= r_ovf | (TX_En_Sig & w_full);
    end

    // Next-state, pop and line level; STOP chains straight into START.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt + BW'(1);
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pin_nxt   = LINE_IDLE;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rd_data;
                    w_state_nxt = START;
                end
            end
            START: begin
                w_pin_nxt = START_LEVEL;
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_pin_nxt = r_shift[0];
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    w_bit_nxt   = r_bit_idx + IW'(1);
                    if (r_bit_idx == BIT_LAST) w_state_nxt = STOP;
                end
            end
            STOP: begin
                w_pin_nxt = STOP_LEVEL;
                if (w_bit_end) begin
                    w_done_nxt = 1'b1;
                    w_baud_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_rd_data;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule
